uart_fifo_regs: RTL

Memory-mapped UART peripheral with parametrised TX and RX FIFOs, a run-time baud divisor, sticky error flags and a level interrupt. It sits on the core's 32-bit data bus inside the hardware-register window, next to SRAM. It replaces the fixed 8-entry RX queue with no TX buffering. Bit-level TX and RX engines are internal, so the block is self-contained.

---
 rtl/uart_fifo_regs.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_regs.sv
// uart_fifo_regs: bus-mapped UART with TX/RX FIFOs, runtime baud divisor,
// sticky error flags and a level interrupt.
module uart_fifo_regs #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_DEPTH  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        irq_o,
    input  logic        rx_i,
    output logic        tx_o
);
    localparam int unsigned TXAW = $clog2(TX_DEPTH);
    localparam int unsigned RXAW = $clog2(RX_DEPTH);
    localparam int unsigned TXCW = TXAW + 1;
    localparam int unsigned RXCW = RXAW + 1;
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD_RATE);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic [15:0]     r_div;
    logic [1:0]      r_irq_en;
    logic            r_rx_ovf, r_tx_ovf, r_frame_err;
    logic [7:0]      r_tx_mem [TX_DEPTH];
    logic [TXAW-1:0] r_tx_wp, r_tx_rp;
    logic [TXCW-1:0] r_tx_cnt;
    logic [7:0]      r_rx_mem [RX_DEPTH];
    logic [RXAW-1:0] r_rx_wp, r_rx_rp;
    logic [RXCW-1:0] r_rx_cnt;
    tx_state_t       r_tx_state, w_tx_state_nxt;
    logic [15:0]     r_tx_tmr, r_tx_div;
    logic [2:0]      r_tx_bit;
    logic [7:0]      r_tx_shift;
    rx_state_t       r_rx_state, w_rx_state_nxt;
    logic [15:0]     r_rx_tmr, r_rx_div;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            r_rx_s1, r_rx_s2, r_rx_prev;

    logic        w_wr_data, w_rd_data, w_wr_stat, w_wr_div, w_wr_irq;
    logic        w_tx_full, w_tx_empty, w_tx_push_ok, w_tx_pop, w_tx_tick, w_tx_done;
    logic        w_rx_full, w_rx_empty, w_rx_push, w_rx_push_ok, w_rx_pop, w_rx_ferr;
    logic        w_rx_start, w_rx_tick, w_rx_half, w_rx_fall;
    logic [31:0] w_status, w_rd_val;
    logic        w_unused;

    assign w_wr_data  = req_i &  we_i & (addr_i[3:2] == 2'd0);
    assign w_rd_data  = req_i & ~we_i & (addr_i[3:2] == 2'd0);
    assign w_wr_stat  = req_i &  we_i & (addr_i[3:2] == 2'd1);
    assign w_wr_div   = req_i &  we_i & (addr_i[3:2] == 2'd2);
    assign w_wr_irq   = req_i &  we_i & (addr_i[3:2] == 2'd3);
    assign w_unused   = ^{wdata_i[31:16], addr_i[1:0]};

    assign w_tx_full    = (r_tx_cnt == TXCW'(TX_DEPTH));
    assign w_tx_empty   = (r_tx_cnt == '0);
    assign w_tx_push_ok = w_wr_data & ~w_tx_full;
    assign w_tx_done    = w_tx_empty & (r_tx_state == TX_IDLE);
    assign w_rx_full    = (r_rx_cnt == RXCW'(RX_DEPTH));
    assign w_rx_empty   = (r_rx_cnt == '0);
    assign w_rx_push_ok = w_rx_push & ~w_rx_full;
    assign w_rx_pop     = w_rd_data & ~w_rx_empty;

    // FIFO storage (no reset needed on the data arrays)
    always_ff @(posedge clk_i) begin
        if (w_tx_push_ok) r_tx_mem[r_tx_wp] <= wdata_i[7:0];
        if (w_rx_push_ok) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
            r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
        end else begin
            if (w_tx_push_ok) r_tx_wp <= r_tx_wp + TXAW'(1);
            if (w_tx_pop)     r_tx_rp <= r_tx_rp + TXAW'(1);
            r_tx_cnt <= r_tx_cnt + TXCW'(w_tx_push_ok) - TXCW'(w_tx_pop);
            if (w_rx_push_ok) r_rx_wp <= r_rx_wp + RXAW'(1);
            if (w_rx_pop)     r_rx_rp <= r_rx_rp + RXAW'(1);
            r_rx_cnt <= r_rx_cnt + RXCW'(w_rx_push_ok) - RXCW'(w_rx_pop);
        end
    end

    // TX engine; STOP chains straight into START so queued frames have no gap
    assign w_tx_tick = (r_tx_tmr == r_tx_div - 16'd1);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            TX_IDLE:  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_state_nxt = TX_START; end
            TX_START: if (w_tx_tick) w_tx_state_nxt = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_state_nxt = TX_STOP;
            TX_STOP:  if (w_tx_tick) begin
                          if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_state_nxt = TX_START; end
                          else w_tx_state_nxt = TX_IDLE;
                      end
            default:  w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_tmr   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_div   <= DIV_RST;
            tx_o       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            tx_o       <= (r_tx_state == TX_START) ? 1'b0 :
                          (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;
            if (w_tx_pop) begin
                r_tx_shift <= r_tx_mem[r_tx_rp];
                r_tx_div   <= r_div;
                r_tx_tmr   <= '0;
                r_tx_bit   <= '0;
            end else if (r_tx_state != TX_IDLE) begin
                if (w_tx_tick) begin
                    r_tx_tmr <= '0;
                    if (r_tx_state == TX_DATA) begin
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= r_tx_bit + 3'd1;
                    end
                end else begin
                    r_tx_tmr <= r_tx_tmr + 16'd1;
                end
            end
        end
    end

    // RX engine; after a bad stop bit it waits for an idle line before re-arming
    assign w_rx_fall = r_rx_prev & ~r_rx_s2;
    assign w_rx_tick = (r_rx_tmr == r_rx_div - 16'd1);
    assign w_rx_half = (r_rx_tmr == (r_rx_div >> 1) - 16'd1);

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_push      = 1'b0;
        w_rx_ferr      = 1'b0;
        w_rx_start     = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) begin w_rx_start = 1'b1; w_rx_state_nxt = RX_START; end
            RX_START: if (w_rx_half) w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
            RX_STOP:  if (w_rx_tick) begin
                          if (r_rx_s2) begin w_rx_push = 1'b1; w_rx_state_nxt = RX_IDLE; end
                          else begin w_rx_ferr = 1'b1; w_rx_state_nxt = RX_WAIT; end
                      end
            RX_WAIT:  if (r_rx_s2) w_rx_state_nxt = RX_IDLE;
            default:  w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_state <= RX_IDLE;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_tmr   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_div   <= DIV_RST;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_s1    <= rx_i;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            if (w_rx_start) begin
                r_rx_div <= r_div;
                r_rx_tmr <= '0;
                r_rx_bit <= '0;
            end else if (r_rx_state == RX_START) begin
                r_rx_tmr <= w_rx_half ? 16'd0 : r_rx_tmr + 16'd1;
            end else if (r_rx_state == RX_DATA || r_rx_state == RX_STOP) begin
                if (w_rx_tick) begin
                    r_rx_tmr <= '0;
                    if (r_rx_state == RX_DATA) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end
                end else begin
                    r_rx_tmr <= r_rx_tmr + 16'd1;
                end
            end
        end
    end

    assign w_status = {8'h0, 8'(r_tx_cnt), 8'(r_rx_cnt), 2'b0, r_frame_err, r_tx_ovf,
                       r_rx_ovf, w_tx_done, ~w_rx_empty, w_tx_full};

    always_comb begin
        w_rd_val = '0;
        case (addr_i[3:2])
            2'd0:    w_rd_val = w_rx_empty ? 32'hFFFF_FFFF : {24'h0, r_rx_mem[r_rx_rp]};
            2'd1:    w_rd_val = w_status;
            2'd2:    w_rd_val = {16'h0, r_div};
            default: w_rd_val = {30'h0, r_irq_en};
        endcase
    end

    // Register file, sticky flags, bus response and interrupt
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div       <= DIV_RST;
            r_irq_en    <= '0;
            r_rx_ovf    <= 1'b0;
            r_tx_ovf    <= 1'b0;
            r_frame_err <= 1'b0;
            rvalid_o    <= 1'b0;
            rdata_o     <= '0;
            irq_o       <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= (req_i && !we_i) ? w_rd_val : 32'h0;
            if (w_wr_div) r_div <= (wdata_i[15:0] < 16'd4) ? 16'd4 : wdata_i[15:0];
            if (w_wr_irq) r_irq_en <= wdata_i[1:0];
            r_rx_ovf    <= (r_rx_ovf & ~(w_wr_stat & wdata_i[3])) | (w_rx_push & w_rx_full);
            r_tx_ovf    <= (r_tx_ovf & ~(w_wr_stat & wdata_i[4])) | (w_wr_data & w_tx_full);
            r_frame_err <= (r_frame_err & ~(w_wr_stat & wdata_i[5])) | w_rx_ferr;
            irq_o       <= (r_irq_en[0] & ~w_rx_empty) | (r_irq_en[1] & w_tx_done);
        end
    end
endmodule
